// File: rtl/acia_tx_ctrl.sv
// ACIA transmitter: R_SBR rate select, 16x BCLK tick, one-byte holding register, 8N1/8E1 shifter (ACIA_TX_PARITY_EN adds even parity).
// Latency: TX_WR to start bit is 2 XTLI cycles when idle; TX_WR while TX_EMPTY=0 is dropped, and rate writes wait for an idle line.
module acia_tx_ctrl #(
    parameter int         OVSMP     = 16,
    parameter int         STOP_BITS = 1,
    parameter logic [3:0] SBR_RST   = 4'hE
) (
    input  logic       XTLI,
    input  logic       RESET,
    input  logic       BCLK_IN,
    input  logic       SBR_WR,
    input  logic [3:0] SBR_DIN,
    output logic [3:0] R_SBR,
    input  logic       TX_WR,
    input  logic [7:0] TX_DIN,
    output logic       TX_EMPTY,
    output logic       BUSY,
    output logic       TXD
);

    localparam logic [5:0] TICK_LAST = 6'(OVSMP - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

`ifdef ACIA_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t      state_q, state_d;
    logic [5:0]  tick_cnt_q, tick_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  hold_q, hold_d;
    logic        empty_q, empty_d;
    logic [3:0]  sbr_q, sbr_d;
    logic        pend_q, pend_d;
    logic [3:0]  pend_sbr_q, pend_sbr_d;
    logic        bclk_q, bclk_d;
    logic        txd_q, txd_d;
`ifdef ACIA_TX_PARITY_EN
    logic        par_q, par_d;
`endif

    logic        tick;
    logic        bit_end;
    logic        rate_req;
    logic        take;

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        empty_d    = empty_q;
        sbr_d      = sbr_q;
        pend_d     = pend_q;
        pend_sbr_d = pend_sbr_q;
        bclk_d     = BCLK_IN;
        txd_d      = txd_q;
        take       = 1'b0;
`ifdef ACIA_TX_PARITY_EN
        par_d      = par_q;
`endif
        // Rate code 0 makes the generator pass XTLI straight through: every cycle is a tick.
        tick     = (sbr_q == 4'h0) || (BCLK_IN && !bclk_q);
        bit_end  = tick && (tick_cnt_q == TICK_LAST);
        rate_req = pend_q || SBR_WR;

        if (TX_WR && empty_q) begin
            hold_d  = TX_DIN;
            empty_d = 1'b0;
        end
        if (SBR_WR) begin
            pend_sbr_d = SBR_DIN;
            pend_d     = 1'b1;
        end
        if (state_q != S_IDLE && tick) begin
            tick_cnt_d = bit_end ? 6'd0 : tick_cnt_q + 6'd1;
        end

        case (state_q)
            S_IDLE: begin
                // A rate change always wins over starting a frame; the start follows a cycle later.
                if (rate_req) begin
                    sbr_d      = SBR_WR ? SBR_DIN : pend_sbr_q;
                    pend_d     = 1'b0;
                    tick_cnt_d = 6'd0;
                end else if (!empty_q) begin
                    take = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef ACIA_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef ACIA_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (bit_idx_q == STOP_LAST) begin
                        bit_idx_d = 3'd0;
                        if (!empty_q && !rate_req) take = 1'b1;
                        else                       state_d = S_IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (take) begin
            state_d    = S_START;
            shift_d    = hold_q;
            empty_d    = 1'b1;
            tick_cnt_d = 6'd0;
            bit_idx_d  = 3'd0;
`ifdef ACIA_TX_PARITY_EN
            par_d      = ^hold_q;
`endif
        end

        // TXD is registered from the next state so the line never glitches.
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
`ifdef ACIA_TX_PARITY_EN
            S_PARITY: txd_d = par_d;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge XTLI or negedge RESET) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= 6'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            hold_q     <= 8'h00;
            empty_q    <= 1'b1;
            sbr_q      <= SBR_RST;
            pend_q     <= 1'b0;
            pend_sbr_q <= 4'h0;
            bclk_q     <= 1'b0;
            txd_q      <= 1'b1;
`ifdef ACIA_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            empty_q    <= empty_d;
            sbr_q      <= sbr_d;
            pend_q     <= pend_d;
            pend_sbr_q <= pend_sbr_d;
            bclk_q     <= bclk_d;
            txd_q      <= txd_d;
`ifdef ACIA_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign R_SBR    = sbr_q;
    assign TX_EMPTY = empty_q;
    assign BUSY     = (state_q != S_IDLE);
    assign TXD      = txd_q;

endmodule

// File: tb/tb_acia_tx_ctrl.sv
// Bench for acia_tx_ctrl: vector table of frames, hand sequences for rate deferral and
// back-to-back, then random writes checked against a frame-level countdown model.
module tb_acia_tx_ctrl;

    localparam int OVS = 16;
`ifdef ACIA_TX_PARITY_EN
    localparam int FB     = 11;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int FB     = 10;
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int FCYC = FB * OVS;

    logic       XTLI, RESET, BCLK_IN, SBR_WR, TX_WR;
    logic [3:0] SBR_DIN, R_SBR;
    logic [7:0] TX_DIN;
    logic       TX_EMPTY, BUSY, TXD;

    int checks   = 0;
    int failures = 0;

    acia_tx_ctrl dut (
        .XTLI(XTLI), .RESET(RESET), .BCLK_IN(BCLK_IN),
        .SBR_WR(SBR_WR), .SBR_DIN(SBR_DIN), .R_SBR(R_SBR),
        .TX_WR(TX_WR), .TX_DIN(TX_DIN),
        .TX_EMPTY(TX_EMPTY), .BUSY(BUSY), .TXD(TXD)
    );

    initial begin
        XTLI = 1'b0;
        forever #5 XTLI = ~XTLI;
    end

    // Baud generator stand-in: one-cycle BCLK pulse every R_SBR cycles (off for codes 0/1).
    initial begin
        int gcnt;
        gcnt    = 0;
        BCLK_IN = 1'b0;
        forever begin
            @(posedge XTLI);
            #1;
            if (R_SBR < 4'd2) begin
                gcnt    = 0;
                BCLK_IN = 1'b0;
            end else begin
                if (gcnt >= int'(R_SBR) - 1) gcnt = 0;
                else                         gcnt = gcnt + 1;
                BCLK_IN = (gcnt == 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int j);
        if (j == 0)               return 1'b0;
        if (j <= 8)               return d[j-1];
        if (PAR_EN && j == 9)     return ^d;
        return 1'b1;
    endfunction

    task automatic pulse_tx(input logic [7:0] b);
        TX_DIN = b;
        TX_WR  = 1'b1;
        @(posedge XTLI);
        #1;
        TX_WR  = 1'b0;
    endtask

    task automatic pulse_sbr(input logic [3:0] v);
        SBR_DIN = v;
        SBR_WR  = 1'b1;
        @(posedge XTLI);
        #1;
        SBR_WR  = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input int maxc, input string name);
        int n;
        n = 0;
        while (BUSY !== lvl && n < maxc) begin
            @(negedge XTLI);
            n++;
        end
        if (BUSY !== lvl) begin
            checks++;
            failures++;
            $display("FAIL %s: BUSY got %b expected %b within %0d cycles", name, BUSY, lvl, maxc);
        end
    endtask

    // Cycles from the rising edge of data bit 0 to its falling edge (use with 8'h55).
    task automatic meas_bit0(output int dur);
        int n;
        n = 0;
        while (TXD !== 1'b0 && n < 5000) begin @(negedge XTLI); n++; end
        n = 0;
        while (TXD !== 1'b1 && n < 5000) begin @(negedge XTLI); n++; end
        dur = 0;
        while (TXD !== 1'b0 && dur < 5000) begin @(negedge XTLI); dur++; end
    endtask

    // Send one byte at rate 0 and sample each bit in its middle.
    task automatic capture(input logic [7:0] b, output logic [10:0] fr, output int blen);
        int n;
        fr   = '1;
        blen = -1;
        pulse_tx(b);
        n = 0;
        while (TXD !== 1'b0 && n < 20) begin @(negedge XTLI); n++; end
        n = 0;
        while (n < 400) begin
            @(negedge XTLI);
            n++;
            if ((n % OVS) == OVS / 2 && (n / OVS) < FB) fr[n / OVS] = TXD;
            if (BUSY === 1'b0) begin
                blen = n;
                break;
            end
        end
    endtask

    typedef struct {
        logic [7:0] din;
        logic       par;
        logic [9:0] frame;   // {stop, data[7:0], start}, bit 0 on the line first
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [10:0] fr, efr;
        int          blen, dur, g, e_txd, e_busy, e_emp;
        bit          bad_hold, seen7;
        logic        wr, sw;
        logic [7:0]  din;
        int          m_rem, m_full, m_p;
        logic [7:0]  m_cur, m_hold;
        logic        rr, acc, take, etxd;

        vecs[0] = '{8'hA5, 1'b0, 10'b1101001010};
        vecs[1] = '{8'h55, 1'b0, 10'b1010101010};
        vecs[2] = '{8'h0F, 1'b0, 10'b1000011110};
        vecs[3] = '{8'h07, 1'b1, 10'b1000001110};
        vecs[4] = '{8'h03, 1'b0, 10'b1000000110};
        vecs[5] = '{8'h00, 1'b0, 10'b1000000000};
        vecs[6] = '{8'hFF, 1'b0, 10'b1111111110};
        vecs[7] = '{8'h80, 1'b1, 10'b1100000000};

        RESET = 1'b0; SBR_WR = 1'b0; SBR_DIN = 4'h0; TX_WR = 1'b0; TX_DIN = 8'h00;
        @(negedge XTLI);
        check("rst_txd", TXD, 1'b1);
        check("rst_busy", BUSY, 1'b0);
        check("rst_empty", TX_EMPTY, 1'b1);
        check("rst_sbr", R_SBR, 4'hE);
        @(posedge XTLI); #1;
        RESET = 1'b1;
        repeat (2) @(posedge XTLI);
        #1;

        // Deferred rate change: frame at E, request F mid-frame.
        pulse_tx(8'h55);
        wait_busy(1'b1, 50, "t4_start");
        pulse_sbr(4'hF);
        @(negedge XTLI);
        check("t4_sbr_held", R_SBR, 4'hE);
        bad_hold = 1'b0;
        g = 0;
        while (BUSY === 1'b1 && g < 6000) begin
            if (R_SBR !== 4'hE) bad_hold = 1'b1;
            @(negedge XTLI);
            g++;
        end
        check("t4_sbr_stable_in_frame", bad_hold, 1'b0);
        check("t4_sbr_at_frame_end", R_SBR, 4'hE);
        @(negedge XTLI);
        check("t4_sbr_applied", R_SBR, 4'hF);
        pulse_tx(8'h55);
        meas_bit0(dur);
        check("t4_bit_len_f", dur, 16 * 15);

        // Last write wins, and the pending rate delays the held byte's start by one cycle.
        pulse_tx(8'h55);
        pulse_sbr(4'h7);
        repeat (3) @(negedge XTLI);
        pulse_sbr(4'hB);
        seen7 = 1'b0;
        g = 0;
        while (BUSY === 1'b1 && g < 6000) begin
            if (R_SBR === 4'h7) seen7 = 1'b1;
            @(negedge XTLI);
            g++;
        end
        check("t5_sbr_at_frame_end", R_SBR, 4'hF);
        g = 0;
        while (BUSY === 1'b0 && g < 10) begin
            if (R_SBR === 4'h7) seen7 = 1'b1;
            @(negedge XTLI);
            g++;
        end
        check("t5_never_7", seen7, 1'b0);
        check("t5_idle_gap", g, 2);
        check("t5_sbr_last", R_SBR, 4'hB);
        meas_bit0(dur);
        check("t5_bit_len_b", dur, 16 * 11);
        wait_busy(1'b0, 5000, "t5_end");

        // Rate write while idle takes effect on the next edge.
        @(posedge XTLI); #1;
        pulse_sbr(4'h0);
        check("sbr_idle_next_edge", R_SBR, 4'h0);

        for (int i = 0; i < 8; i++) begin
            capture(vecs[i].din, fr, blen);
            efr = PAR_EN ? {1'b1, vecs[i].par, vecs[i].frame[8:0]} : {1'b1, vecs[i].frame};
            check($sformatf("frame_%02h", vecs[i].din), fr, efr);
            check($sformatf("busy_len_%02h", vecs[i].din), blen, FCYC);
        end

        // Back-to-back: 55 then 0F accepted, FF dropped while holding is full.
        @(posedge XTLI); #1;
        e_txd = 0; e_busy = 0; e_emp = 0;
        for (int c = 0; c < 2 * FCYC + 20; c++) begin
            TX_WR  = (c == 0) || (c == 10) || (c == 20);
            TX_DIN = (c == 0) ? 8'h55 : (c == 10) ? 8'h0F : 8'hFF;
            @(negedge XTLI);
            if (c >= 2 && c < FCYC + 2)               etxd = exp_bit(8'h55, (c - 2) / OVS);
            else if (c >= FCYC + 2 && c < 2*FCYC + 2) etxd = exp_bit(8'h0F, (c - FCYC - 2) / OVS);
            else                                      etxd = 1'b1;
            if (TXD !== etxd) e_txd++;
            if (BUSY !== (c >= 2 && c < 2 * FCYC + 2)) e_busy++;
            if (TX_EMPTY !== !(c == 1 || (c >= 11 && c < FCYC + 2))) e_emp++;
            @(posedge XTLI); #1;
        end
        TX_WR = 1'b0;
        check("b2b_txd_errs", e_txd, 0);
        check("b2b_busy_errs", e_busy, 0);
        check("b2b_empty_errs", e_emp, 0);

        // Random writes and rate-0 rewrites against a frame-countdown model.
        m_rem = 0; m_full = 0; m_p = 0; m_cur = 8'h00; m_hold = 8'h00;
        for (int k = 0; k < 4000 && failures < 40; k++) begin
            wr  = ($urandom_range(0, 11) == 0);
            sw  = ($urandom_range(0, 49) == 0);
            din = 8'($urandom);
            TX_WR = wr; TX_DIN = din; SBR_WR = sw; SBR_DIN = 4'h0;
            @(negedge XTLI);
            etxd = (m_rem == 0) ? 1'b1 : exp_bit(m_cur, (FCYC - m_rem) / OVS);
            check("rnd_txd", TXD, etxd);
            check("rnd_busy", BUSY, m_rem != 0);
            check("rnd_empty", TX_EMPTY, m_full == 0);
            @(posedge XTLI);
            rr   = (m_p != 0) || sw;
            acc  = wr && (m_full == 0);
            take = 1'b0;
            if (m_rem == 0) begin
                if (rr)               m_p = 0;
                else if (m_full != 0) take = 1'b1;
            end else begin
                if (m_rem == 1 && m_full != 0 && !rr) take = 1'b1;
                m_p   = rr ? 1 : 0;
                m_rem = m_rem - 1;
            end
            if (take) begin
                m_cur  = m_hold;
                m_rem  = FCYC;
                m_full = 0;
            end
            if (acc) begin
                m_full = 1;
                m_hold = din;
            end
            #1;
        end
        TX_WR = 1'b0; SBR_WR = 1'b0;
        repeat (2 * FCYC + 10) @(negedge XTLI);

        // Asynchronous reset in the middle of a frame.
        pulse_tx(8'hA5);
        repeat (50) @(negedge XTLI);
        RESET = 1'b0;
        #1;
        check("rst_mid_txd", TXD, 1'b1);
        check("rst_mid_busy", BUSY, 1'b0);
        check("rst_mid_empty", TX_EMPTY, 1'b1);
        check("rst_mid_sbr", R_SBR, 4'hE);
        @(posedge XTLI); #1;
        RESET = 1'b1;
        repeat (2) @(posedge XTLI);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
